// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding modes, flag indices, FSM states and canonical NaN for the FPU units
package fpu_pkg;
    typedef enum logic [1:0] {RM_RNE = 2'd0, RM_RTZ = 2'd1, RM_RUP = 2'd2, RM_RDN = 2'd3} rm_e;
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
    } state_e;
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter; returns W for an all-zero input
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count
);
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++)
            if (din[i]) count = CW'(W - 1 - i);
    end
endmodule

// File: rtl/fp_addsub_param.sv
// fp_addsub_param: multi-cycle IEEE-754 add/subtract with parametrised widths,
// four rounding modes, exception flags and a fixed-latency valid/ready handshake
module fp_addsub_param import fpu_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_op,
    input  logic [1:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic [3:0]             out_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int CW = $clog2(MW + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W));

    state_e state;
    logic [W-1:0] a_r, b_r, spec_z, z_c;
    logic op_r, sl, sub, special, spec_nv, zero_sign, zero_r, nx;
    rm_e rm_r;
    logic [EXP_W-1:0] el, es, ea, eb;
    logic [MAN_W:0] ml, ms, ma, mb;
    logic [MW-1:0] xl, xs, aligned, nm, nm_c;
    logic [MW:0] sum, sum_c;
    logic [EXP_W:0] ne, ne_c, re, re_c;
    logic [MAN_W-1:0] rf, rf_c;
    logic [MAN_W+1:0] rnd;
    logic [CW-1:0] lz;
    logic [31:0] em1, sh;
    logic [3:0] f_c;
    logic sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, b_big, inc, grs, ovf, to_inf;

    // Unpack: denormals take effective exponent 1 with a clear hidden bit
    always_comb begin
        sa    = a_r[W-1];
        sb    = b_r[W-1] ^ op_r;
        ea    = a_r[W-2:MAN_W] == '0 ? EXP_W'(1) : a_r[W-2:MAN_W];
        eb    = b_r[W-2:MAN_W] == '0 ? EXP_W'(1) : b_r[W-2:MAN_W];
        ma    = {a_r[W-2:MAN_W] != '0, a_r[MAN_W-1:0]};
        mb    = {b_r[W-2:MAN_W] != '0, b_r[MAN_W-1:0]};
        za    = ma == '0;
        zb    = mb == '0;
        nan_a = &a_r[W-2:MAN_W] & |a_r[MAN_W-1:0];
        nan_b = &b_r[W-2:MAN_W] & |b_r[MAN_W-1:0];
        inf_a = &a_r[W-2:MAN_W] & ~|a_r[MAN_W-1:0];
        inf_b = &b_r[W-2:MAN_W] & ~|b_r[MAN_W-1:0];
        b_big = {eb, mb} > {ea, ma};
    end

    always_comb begin
        aligned = 32'(el - es) >= MAN_W + 3 ? {{(MW-1){1'b0}}, |ms}
                : ({ms, 3'b000} >> (el - es))
                  | {{(MW-1){1'b0}}, |({ms, 3'b000} & ~({MW{1'b1}} << (el - es)))};
        sum_c   = sub ? {1'b0, xl} - {1'b0, xs} : {1'b0, xl} + {1'b0, xs};
    end

    fp_lzc #(.W(MW)) u_lzc (.din(sum[MW-1:0]), .count(lz));

    // Normalise: left shift is clamped so the exponent never falls below 1
    always_comb begin
        em1  = 32'(el) - 32'd1;
        sh   = 32'(lz) < em1 ? 32'(lz) : em1;
        nm_c = sum[MW] ? {sum[MW:2], sum[1] | sum[0]} : sum[MW-1:0] << sh;
        ne_c = sum[MW] ? {1'b0, el} + (EXP_W+1)'(1) : (EXP_W+1)'(32'(el) - sh);
    end

    always_comb begin
        grs  = nm[2] | nm[1] | nm[0];
        inc  = rm_r == RM_RNE ? nm[2] & (nm[1] | nm[0] | nm[3])
             : rm_r == RM_RTZ ? 1'b0
             : rm_r == RM_RUP ? grs & ~sl : grs & sl;
        rnd  = {1'b0, nm[MW-1:3]} + (MAN_W+2)'(inc);
        re_c = rnd[MAN_W+1] ? ne + (EXP_W+1)'(1) : rnd[MAN_W] ? ne : '0;
        rf_c = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    end

    always_comb begin
        ovf    = re >= {1'b0, EMAX};
        to_inf = rm_r == RM_RNE | (rm_r == RM_RUP & ~sl) | (rm_r == RM_RDN & sl);
        z_c    = special ? spec_z
               : zero_r ? {zero_sign, {(W-1){1'b0}}}
               : ovf ? (to_inf ? {sl, EMAX, {MAN_W{1'b0}}} : {sl, EMAX - EXP_W'(1), {MAN_W{1'b1}}})
               : {sl, re[EXP_W-1:0], rf};
        f_c    = special ? {spec_nv, 3'b000}
               : zero_r ? 4'b0000 : {1'b0, ovf, ~|re & nx, nx | ovf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    state    <= S_UNPACK;
                    in_ready <= 1'b0;
                end
                S_PACK: begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    out_z     <= z_c;
                    out_flags <= f_c;
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= state_e'(state + 3'd1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (in_valid && in_ready) begin
                a_r  <= in_a;
                b_r  <= in_b;
                op_r <= in_op;
                rm_r <= rm_e'(in_rm);
            end
            S_UNPACK: begin
                sl        <= b_big ? sb : sa;
                sub       <= sa ^ sb;
                el        <= b_big ? eb : ea;
                es        <= b_big ? ea : eb;
                ml        <= b_big ? mb : ma;
                ms        <= b_big ? ma : mb;
                special   <= nan_a | nan_b | inf_a | inf_b;
                spec_nv   <= nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
                spec_z    <= (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb))) ? QNAN
                           : inf_a ? {sa, EMAX, {MAN_W{1'b0}}} : {sb, EMAX, {MAN_W{1'b0}}};
                zero_sign <= (za & zb & ~(sa ^ sb)) ? sa : rm_r == RM_RDN;
            end
            S_ALIGN: begin
                xl <= {ml, 3'b000};
                xs <= aligned;
            end
            S_ADD: sum <= sum_c;
            S_NORM: begin
                nm     <= nm_c;
                ne     <= ne_c;
                zero_r <= sum == '0;
            end
            S_ROUND: begin
                re <= re_c;
                rf <= rf_c;
                nx <= grs;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fp_addsub_param.sv
// tb_fp_addsub_param: table-driven check of single and half precision instances plus handshake corners
module tb_fp_addsub_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v32 = 1'b0, r32 = 1'b1, ir32, o32, op32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, z32;
    logic [1:0] rm32 = '0;
    logic [3:0] f32;
    logic v16 = 1'b0, r16 = 1'b1, ir16, o16, op16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, z16;
    logic [1:0] rm16 = '0;
    logic [3:0] f16;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32),
        .in_op(op32), .in_rm(rm32), .out_valid(o32), .out_ready(r32), .out_z(z32), .out_flags(f32));
    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_op(op16), .in_rm(rm16), .out_valid(o16), .out_ready(r16), .out_z(z16), .out_flags(f16));

    typedef struct {
        bit          h;
        logic [31:0] a, b;
        logic        op;
        logic [1:0]  rm;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;
    vec_t vt[$];
    int n_tot = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [1:0] rm);
        if (h) begin
            a16 = a[15:0]; b16 = b[15:0]; op16 = op; rm16 = rm; v16 = 1'b1;
        end else begin
            a32 = a; b32 = b; op32 = op; rm32 = rm; v32 = 1'b1;
        end
        @(posedge clk); #1;
        v16 = 1'b0;
        v32 = 1'b0;
    endtask

    task automatic wait_out(input bit h, output int lat);
        lat = 0;
        while (!(h ? o16 : o32) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bad;
        logic [31:0] zs;
        logic [3:0] fs;
        vt.push_back('{0, 32'h3F800000, 32'h40000000, 0, 2'd0, 32'h40400000, 4'h0});
        vt.push_back('{0, 32'h3F800000, 32'h3F800000, 1, 2'd0, 32'h00000000, 4'h0});
        vt.push_back('{0, 32'h3F800000, 32'h3F800000, 1, 2'd3, 32'h80000000, 4'h0});
        vt.push_back('{0, 32'h7F800000, 32'hFF800000, 0, 2'd0, 32'h7FC00000, 4'h8});
        vt.push_back('{0, 32'h7FC00001, 32'h3F800000, 0, 2'd0, 32'h7FC00000, 4'h8});
        vt.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd0, 32'h7F800000, 4'h5});
        vt.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd1, 32'h7F7FFFFF, 4'h5});
        vt.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd2, 32'h7F800000, 4'h5});
        vt.push_back('{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'd3, 32'h7F7FFFFF, 4'h5});
        vt.push_back('{0, 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'd2, 32'hFF7FFFFF, 4'h5});
        vt.push_back('{0, 32'h3F800000, 32'h33800000, 0, 2'd0, 32'h3F800000, 4'h1});
        vt.push_back('{0, 32'h3F800000, 32'h33800000, 0, 2'd2, 32'h3F800001, 4'h1});
        vt.push_back('{0, 32'h3F800000, 32'h33800000, 0, 2'd1, 32'h3F800000, 4'h1});
        vt.push_back('{0, 32'hBF800000, 32'hB3800000, 0, 2'd3, 32'hBF800001, 4'h1});
        vt.push_back('{0, 32'h3FFFFFFF, 32'h33800000, 0, 2'd0, 32'h40000000, 4'h1});
        vt.push_back('{0, 32'h3F800000, 32'h0DA24260, 0, 2'd2, 32'h3F800001, 4'h1});
        vt.push_back('{0, 32'h00000001, 32'h00000001, 0, 2'd0, 32'h00000002, 4'h0});
        vt.push_back('{0, 32'h00400000, 32'h00400000, 0, 2'd0, 32'h00800000, 4'h0});
        vt.push_back('{0, 32'h3F800001, 32'h3F800000, 1, 2'd0, 32'h34000000, 4'h0});
        vt.push_back('{0, 32'h40400000, 32'h3F800000, 1, 2'd0, 32'h40000000, 4'h0});
        vt.push_back('{0, 32'h3F800000, 32'h40000000, 1, 2'd0, 32'hBF800000, 4'h0});
        vt.push_back('{0, 32'h80000000, 32'h80000000, 0, 2'd0, 32'h80000000, 4'h0});
        vt.push_back('{0, 32'h7F800000, 32'h3F800000, 0, 2'd0, 32'h7F800000, 4'h0});
        vt.push_back('{1, 32'h3C00, 32'h3C00, 0, 2'd0, 32'h4000, 4'h0});
        vt.push_back('{1, 32'h3C00, 32'h3C00, 1, 2'd0, 32'h0000, 4'h0});
        vt.push_back('{1, 32'h7BFF, 32'h7BFF, 0, 2'd0, 32'h7C00, 4'h5});
        vt.push_back('{1, 32'h0001, 32'h0001, 0, 2'd0, 32'h0002, 4'h0});

        #12;
        chk("reset.valid", {31'd0, o32}, 32'd0);
        chk("reset.z", z32, 32'd0);
        chk("reset.flags", {28'd0, f32}, 32'd0);
        chk("reset.ready", {31'd0, ir32}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            start(vt[i].h, vt[i].a, vt[i].b, vt[i].op, vt[i].rm);
            wait_out(vt[i].h, lat);
            chk($sformatf("v%0d.latency", i), lat, 32'd6);
            chk($sformatf("v%0d.z", i), vt[i].h ? {16'd0, z16} : z32, vt[i].z);
            chk($sformatf("v%0d.flags", i), {28'd0, vt[i].h ? f16 : f32}, {28'd0, vt[i].f});
            @(posedge clk); #1;
        end

        r32 = 1'b0;
        start(0, 32'h3F800000, 32'h40000000, 1'b0, 2'd0);
        wait_out(0, lat);
        chk("stall.latency", lat, 32'd6);
        zs = z32;
        fs = f32;
        a32 = 32'h7F800000;
        v32 = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (z32 !== zs || f32 !== fs || ir32 !== 1'b0 || o32 !== 1'b1) bad++;
        end
        v32 = 1'b0;
        chk("stall.hold", bad, 32'd0);
        chk("stall.z", zs, 32'h40400000);
        chk("stall.flags", {28'd0, fs}, 32'd0);
        r32 = 1'b1;
        @(posedge clk); #1;
        chk("stall.release", {30'd0, o32, ir32}, 32'd1);

        start(0, 32'h3F800000, 32'h40000000, 1'b0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("abort.valid_in_reset", {31'd0, o32}, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o32 !== 1'b0) bad++;
        end
        chk("abort.no_output", bad, 32'd0);
        chk("abort.ready", {31'd0, ir32}, 32'd1);
        start(0, 32'h40400000, 32'h3F800000, 1'b1, 2'd0);
        wait_out(0, lat);
        chk("abort.next_latency", lat, 32'd6);
        chk("abort.next_z", z32, 32'h40000000);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end
endmodule
